// File: rtl/chunked_serial_adder.sv
// Multi-cycle two's-complement adder: adds CHUNK bits per clock with a registered carry.
// Optional macro OVERFLOW_EN enables the registered signed-overflow flag.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [31:0]      base_s;
    logic [CHUNK-1:0] x_chunk_s;
    logic [CHUNK-1:0] y_chunk_s;
    logic [CHUNK:0]   sum_s;
    logic [WIDTH-1:0] acc_s;
    logic             last_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = IDLE;
                else        state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode: busy covers exactly the RUN cycles
    always_comb begin
        busy = 1'b0;
        case (state_r)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // One chunk add per cycle; shifts keep the chunk mux free of wide selects
    always_comb begin
        base_s    = 32'(idx_r) * 32'(CHUNK);
        x_chunk_s = CHUNK'(x_r >> base_s);
        y_chunk_s = CHUNK'(y_r >> base_s);
        sum_s     = {1'b0, x_chunk_s} + {1'b0, y_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        acc_s     = (acc_r & ~(CHUNK_MASK << base_s)) | (WIDTH'(sum_s[CHUNK-1:0]) << base_s);
        last_s    = (idx_r == LAST_IDX);
    end

    // Operand capture, chunk accumulation and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r   <= IDX_ZERO;
            carry_r <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            done    <= 1'b0;
            z       <= {WIDTH{1'b0}};
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r     <= x;
                        y_r     <= y;
                        carry_r <= cin;
                        idx_r   <= IDX_ZERO;
                    end else begin
                        idx_r   <= idx_r;
                    end
                end
                RUN: begin
                    acc_r   <= acc_s;
                    carry_r <= sum_s[CHUNK];
                    if (last_s) begin
                        idx_r <= IDX_ZERO;
                        z     <= acc_s;
                        carry <= sum_s[CHUNK];
                        done  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                default: idx_r <= IDX_ZERO;
            endcase
        end
    end

`ifdef OVERFLOW_EN
    logic overflow_r;

    // Signed overflow: like-signed operands producing a sum of the other sign
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            overflow_r <= (x_r[WIDTH-1] == y_r[WIDTH-1]) && (acc_s[WIDTH-1] != x_r[WIDTH-1]);
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder (WIDTH=16, CHUNK=4) against a whole-word add model.
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] z;
    logic        carry;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .cin(cin),
        .busy(busy), .done(done), .z(z), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 17-bit addition plus sign rule
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  output logic [15:0] ze, output logic ce, output logic ve);
        logic [16:0] s;
        s  = 17'(a) + 17'(b) + 17'(c);
        ze = s[15:0];
        ce = s[16];
`ifdef OVERFLOW_EN
        ve = (a[15] == b[15]) && (ze[15] != a[15]);
`else
        ve = 1'b0;
`endif
    endfunction

    // Drives one start and follows it to done (bounded), reporting what was seen
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int lat, output logic [15:0] zo, output logic co, output logic vo,
                          output bit busy_ok, output logic [15:0] zfirst, output bit zstable);
        x = a; y = b; cin = c; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        zfirst = z;
        zstable = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (z !== zfirst) zstable = 1'b0;
            end
        end
        zo = z; co = carry; vo = overflow;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; x = 16'hFFFF; y = 16'h0001; cin = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL reset_z: got %h expected 0000", z); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0; start = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb [4] = '{16'h1111, 16'h0000, 16'h0001, 16'h8000};
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] vz [4] = '{16'h2345, 16'h0000, 16'h8000, 16'h0000};
        logic        vk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int lat; logic [15:0] zo, zf, ze; logic co, vo, ce, ve; bit bok, zs;
        for (int i = 0; i < 4; i++) begin
            model(va[i], vb[i], vc[i], ze, ce, ve);
            run_op(va[i], vb[i], vc[i], lat, zo, co, vo, bok, zf, zs);
            checks++; if (lat != 5) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 5", i, lat); end
            checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy: got bad busy/done pattern expected 4 busy cycles then done", i); end
            checks++; if (zo !== vz[i]) begin errors++; $display("FAIL dir%0d_z: got %h expected %h", i, zo, vz[i]); end
            checks++; if (co !== vk[i]) begin errors++; $display("FAIL dir%0d_carry: got %b expected %b", i, co, vk[i]); end
            checks++; if (vo !== ve) begin errors++; $display("FAIL dir%0d_overflow: got %b expected %b", i, vo, ve); end
            step();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        logic [15:0] zd = 16'hDEAD;
        x = 16'h0001; y = 16'h0001; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        x = 16'hAAAA; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) begin ndone++; zd = z; end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", ndone); end
        checks++; if (zd !== 16'h0002) begin errors++; $display("FAIL busy_start_z: got %h expected 0002", zd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat; logic [15:0] zo, zf; logic co, vo; bit bok, zs;
        x = 16'hFFFF; y = 16'h0001; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
        checks++; if (z !== 16'h0000) begin errors++; $display("FAIL abort_z: got %h expected 0000", z); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL abort_carry: got %b expected 0", carry); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        run_op(16'h0003, 16'h0004, 1'b0, lat, zo, co, vo, bok, zf, zs);
        checks++; if (zo !== 16'h0007) begin errors++; $display("FAIL abort_next_z: got %h expected 0007", zo); end
        checks++; if (lat != 5) begin errors++; $display("FAIL abort_next_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] zo, zf; logic co, vo; bit bok, zs;
        run_op(16'h4321, 16'h0101, 1'b0, lat, zo, co, vo, bok, zf, zs);
        checks++; if (zo !== 16'h4422) begin errors++; $display("FAIL b2b_first_z: got %h expected 4422", zo); end
        run_op(16'h00FF, 16'h0001, 1'b0, lat, zo, co, vo, bok, zf, zs);
        checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL b2b_busy: got bad busy/done pattern expected accepted in done cycle"); end
        checks++; if (zf !== 16'h4422 || !zs) begin errors++; $display("FAIL b2b_z_held: got %h stable=%0d expected 4422 stable=1", zf, zs); end
        checks++; if (zo !== 16'h0100) begin errors++; $display("FAIL b2b_z: got %h expected 0100", zo); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL b2b_carry: got %b expected 0", co); end
    endtask

    task automatic test_random();
        int lat; logic [15:0] a, b, zo, zf, ze; logic c, co, vo, ce, ve; bit bok, zs;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
            model(a, b, c, ze, ce, ve);
            run_op(a, b, c, lat, zo, co, vo, bok, zf, zs);
            checks++;
            if (lat != 5 || !bok || zo !== ze || co !== ce || vo !== ve) begin
                errors++;
                $display("FAIL rand%0d %h+%h+%b: got z=%h c=%b v=%b lat=%0d busy_ok=%0d expected z=%h c=%b v=%b lat=5",
                         i, a, b, c, zo, co, vo, lat, bok, ze, ce, ve);
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = 16'h0000; y = 16'h0000; cin = 1'b0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Multi-cycle, parametrised two's-complement adder that adds two WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks. It succeeds the fixed 5-bit combinational ripple adder. It trades latency for a short carry chain, so wide datapaths can add without a WIDTH-long combinational path. The carry-in is honoured, and start/busy/done handshaking is provided for use by datapath controllers.

## Interface
- WIDTH, 16: operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  WIDTH  operand A; captured with start.
- y  in  WIDTH  operand B; captured with start.
- cin  in  1  carry-in to bit 0; captured with start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; z, carry and overflow are valid from this cycle.
- z  out  WIDTH  sum, registered.
- carry  out  1  carry-out of bit WIDTH-1, registered.
- overflow  out  1  signed overflow flag; see Configuration.

## Operation
- States: IDLE, RUN. A chunk index idx runs 0..NCHUNK-1.
- IDLE with start=1:
  - Capture x, y and cin into operand registers.
  - Set carry_r = cin and idx = 0, then go to RUN.
- IDLE with start=0: hold.
- RUN, each edge:
  - Compute {c, s} = x_r[idx*CHUNK +: CHUNK] + y_r[idx*CHUNK +: CHUNK] + carry_r, a (CHUNK+1)-bit add.
  - Write s into acc[idx*CHUNK +: CHUNK], set carry_r = c and increment idx.
- RUN with idx = NCHUNK-1:
  - The edge loads z = the completed acc (including the final chunk), carry = c, and overflow.
  - done is set for one cycle and the state returns to IDLE.
- start while in RUN is ignored. Captured operands never change mid-operation.
- z, carry and overflow hold their values from done until the next completion. They are not cleared by a new start.
- Arithmetic is modulo 2^WIDTH. carry is the true unsigned carry-out.
- Reset (any state):
  - State goes to IDLE; idx, carry_r and acc are set to 0.
  - busy=0, done=0, z=0, carry=0, overflow=0.
  - An in-flight addition is aborted and no done is produced.

## Timing
- Start sampled at edge E0: busy=1 from after E0.
- Chunk k is processed at edge E0+1+k.
- done=1 and results are valid in the cycle after edge E0+NCHUNK. Latency is NCHUNK+1 edges from start sampling to done.
- busy is 0 in the done cycle, because the state is already IDLE. A start asserted in the done cycle is accepted, giving a throughput of one result per NCHUNK+1 cycles.
- CHUNK = WIDTH gives a single RUN cycle and a latency of 2.
- Reset takes priority over start at the same edge.
- The critical path is a CHUNK-bit add plus the index mux, independent of WIDTH.

## Configuration
- OVERFLOW_EN defined:
  - overflow is registered with z at completion.
  - overflow = (x_r[WIDTH-1] == y_r[WIDTH-1]) && (z_new[WIDTH-1] != x_r[WIDTH-1]).
  - cin is included in the sum z_new.
- OVERFLOW_EN undefined: the overflow port is present and tied to 0. No overflow logic is synthesised.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Basic add: x=0x1234, y=0x1111, cin=0, start for one cycle → busy for 4 cycles, then done in the 5th cycle after start sampling, with z=0x2345, carry=0.
- Full carry ripple: x=0xFFFF, y=0x0000, cin=1 → z=0x0000, carry=1. The carry must cross every chunk boundary.
- Signed overflow: x=0x7FFF, y=0x0001, cin=0 → z=0x8000, carry=0. overflow=1 with OVERFLOW_EN and 0 without it. Then x=0x8000, y=0x8000 → z=0x0000, carry=1, overflow=1 (with OVERFLOW_EN).
- Start while busy: start with x=0x0001, y=0x0001, then re-assert start with x=0xAAAA on the 2nd busy cycle → a single done with z=0x0002. No second done.
- Reset mid-operation: reset on the 2nd RUN cycle → the next cycle shows busy=0, done=0, z=0, carry=0 and no done pulse. A subsequent start with 0x0003+0x0004 gives z=0x0007.
- Back-to-back: start re-asserted in the done cycle with x=0x00FF, y=0x0001 → accepted, and a second done 5 cycles later with z=0x0100, carry=0. The previous z is held until then.
